// File: rtl/bit_serial_alu_if.sv
// Operand/result bundle for bit_serial_alu. The requester drives the operands
// and start; the ALU returns status and the registered result.
interface bit_serial_alu_if #(parameter int WIDTH = 8);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (output start, mode, a, b,
                    input  busy, done, sum, c_out, ovf);
    modport slave  (input  start, mode, a, b,
                    output busy, done, sum, c_out, ovf);
endinterface

// File: rtl/bit_serial_alu.sv
// Bit-serial add/subtract: one full-adder step per clock, LSB first, WIDTH
// clocks per operation, with the parallel result registered on completion.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    bit_serial_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] r_nxt;

    assign s_bit = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nxt = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign r_nxt = {s_bit, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            r_sr      <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.sum   <= '0;
            bus.c_out <= 1'b0;
            bus.ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1: invert b and seed the carry with 1.
                        a_sr     <= bus.a;
                        b_sr     <= bus.mode ? ~bus.b : bus.b;
                        carry    <= bus.mode;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        state    <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    r_sr  <= r_nxt;
                    carry <= c_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry still holds the carry into the MSB on this edge.
                        bus.sum   <= r_nxt;
                        bus.c_out <= c_nxt;
                        bus.ovf   <= carry ^ c_nxt;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 a  input  WIDTH  parallel operand A; sampled with start.
REQ-007 b  input  WIDTH  parallel operand B; sampled with start.
REQ-008 busy  output  1  high while serial processing is in progress.
REQ-009 done  output  1  single-cycle pulse; result outputs are valid from this cycle.
REQ-010 sum  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-011 c_out  output  1  final carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-012 ovf  output  1  two's-complement signed overflow of the completed operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 at an edge SHALL load the A shift register with a, and the B shift register with b (mode=0) or ~b (mode=1).
REQ-015 The same IDLE start edge SHALL initialise carry to mode, clear the bit counter, and enter SHIFT.
REQ-016 SHIFT: each edge SHALL full-add the LSBs of A, B and carry, then shift A and B right by one.
REQ-017 On the same SHIFT edge, the sum bit SHALL enter the MSB of an internal result shift register, which shifts right; carry SHALL be updated and the counter incremented.
REQ-018 SHIFT SHALL last exactly WIDTH edges; LSB first; one bit per cycle, with no stall.
REQ-019 On the WIDTH-th SHIFT edge: sum <= completed result; c_out <= final carry; ovf <= carry into MSB XOR carry out of MSB; state <= DONE.
REQ-020 busy SHALL equal 1 exactly in SHIFT.
REQ-021 done SHALL equal 1 exactly in DONE (one cycle), i.e. WIDTH+1 edges after the start-sampling edge.
REQ-022 sum, c_out and ovf SHALL change only at completion or reset.
REQ-023 sum, c_out and ovf SHALL hold their values through IDLE and through any subsequent SHIFT until the next completion.
REQ-024 DONE: start=1 SHALL be accepted exactly as in IDLE (back-to-back operation); start=0 SHALL return to IDLE.
REQ-025 start, a, b and mode SHALL be ignored while busy=1; their changes during SHIFT SHALL NOT affect the result.
REQ-026 Result arithmetic: sum = (a + b) mod 2^WIDTH (add) or (a + ~b + 1) mod 2^WIDTH (subtract).

Reset
REQ-027 reset=0 at an edge SHALL force IDLE, and clear busy, done, sum, c_out, ovf, the counter, carry and all shift registers, in any state.
REQ-028 reset SHALL take priority over start, and SHALL abort an in-progress operation without producing done.
REQ-029 The first start sampled after reset returns to 1 SHALL run a normal full-length operation.

Verification
REQ-030 WIDTH=8, add, a=123, b=32 -> done 9 edges after start; sum=155, c_out=0, ovf=1.
REQ-031 WIDTH=8, sub, a=32, b=123 -> sum=165 (0xA5), c_out=0, ovf=0; sub, a=3, b=12 -> sum=247, c_out=0, ovf=0.
REQ-032 WIDTH=8, add, a=200, b=100 -> sum=44, c_out=1, ovf=0; then start in the DONE cycle with add 16+6 -> done after a further 9 edges with sum=22; busy=1 throughout the second operation.
REQ-033 WIDTH=16, add, a=40000, b=30000 -> done 17 edges after start; sum=4464, c_out=1, ovf=0.
REQ-034 Reset mid-operation: start 123+32, drive reset=0 on the 3rd SHIFT edge -> next edge busy=0, done=0, sum=0; no done pulse follows; a new start 3+12 yields sum=15.
REQ-035 Ignored start: while busy, pulse start with a=1, b=1 -> the current result is unaffected, and no extra operation or done pulse occurs.
